// File: rtl/l15_int_ctrl_if.sv
// L1.5 interrupt-return packet channel: valid/ready handshake with a 64-bit payload.
interface l15_int_ctrl_if;
   logic        int_val_i;
   logic        int_ready_o;
   logic [63:0] int_data_i;

   modport master (
      output int_val_i,
      output int_data_i,
      input  int_ready_o
   );

   modport slave (
      input  int_val_i,
      input  int_data_i,
      output int_ready_o
   );
endinterface

// File: rtl/l15_int_ctrl.sv
// Core interrupt controller: waits out SRAM init, releases core reset on a wake packet, drives IPI/IRQ levels.
// Optional debug-request stretching is enabled by defining L15_INT_CTRL_DEBUG_EN.
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_INIT      | SRAM init wait, packets not accepted, core held in reset
// ST_WAIT_WAKE | packets accepted, core held in reset until a wake packet
// ST_RUN       | core running, wake packets ignored
module l15_int_ctrl #(
   parameter int InitCycles      = 32768,
   parameter int DebugHoldCycles = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   l15_int_ctrl_if.slave        int_if,
   output logic                 core_rst_no,
   output logic [1:0]           irq_o,
   output logic                 ipi_o,
   output logic                 debug_req_o,
   output logic [1:0]           state_o
);

   typedef enum logic [1:0] {
      ST_INIT      = 2'd0,
      ST_WAIT_WAKE = 2'd1,
      ST_RUN       = 2'd2
   } state_t;

   localparam logic [1:0] TypeWake  = 2'd0;
   localparam logic [1:0] TypeIpi   = 2'd1;
   localparam logic [1:0] TypeIrq   = 2'd2;
   localparam logic [1:0] TypeDebug = 2'd3;

   localparam int CntW = (InitCycles > 1) ? $clog2(InitCycles) : 1;
   localparam logic [CntW-1:0] InitLast = (InitCycles > 0) ? CntW'(InitCycles - 1) : '0;

   state_t          state;
   state_t          state_nxt;
   logic [CntW-1:0] init_cnt;
   logic [CntW-1:0] init_cnt_nxt;

   logic       accept;
   logic [1:0] pkt_type;
   logic       pkt_set;
   logic [1:0] pkt_mask;

   assign pkt_type = int_if.int_data_i[17:16];
   assign pkt_set  = int_if.int_data_i[8];
   assign pkt_mask = int_if.int_data_i[1:0];

   assign int_if.int_ready_o = (state != ST_INIT);
   assign accept             = int_if.int_val_i && int_if.int_ready_o;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state    <= ST_INIT;
         init_cnt <= '0;
      end else begin
         state    <= state_nxt;
         init_cnt <= init_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      init_cnt_nxt = init_cnt;
      case (state)
         ST_INIT: begin
            if ((InitCycles == 0) || (init_cnt == InitLast)) begin
               state_nxt = ST_WAIT_WAKE;
            end else begin
               init_cnt_nxt = init_cnt + 1'b1;
            end
         end
         ST_WAIT_WAKE: begin
            if (accept && (pkt_type == TypeWake)) begin
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            state_nxt = ST_RUN;
         end
         default: begin
            state_nxt = ST_INIT;
         end
      endcase
   end

   // RUN is entered the edge after the wake packet, so core reset release tracks it directly.
   assign core_rst_no = (state == ST_RUN);
   assign state_o     = state;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         ipi_o <= 1'b0;
         irq_o <= 2'b00;
      end else if (accept) begin
         if (pkt_type == TypeIpi) begin
            ipi_o <= pkt_set;
         end
         if (pkt_type == TypeIrq) begin
            irq_o <= pkt_set ? (irq_o | pkt_mask) : (irq_o & ~pkt_mask);
         end
      end
   end

`ifdef L15_INT_CTRL_DEBUG_EN
   logic [7:0] dbg_cnt;

   // A new debug packet reloads rather than extends the hold window.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         dbg_cnt <= 8'd0;
      end else if (accept && (pkt_type == TypeDebug)) begin
         dbg_cnt <= 8'(DebugHoldCycles);
      end else if (dbg_cnt != 8'd0) begin
         dbg_cnt <= dbg_cnt - 8'd1;
      end
   end

   assign debug_req_o = (dbg_cnt != 8'd0);
`else
   logic unused_dbg_cfg;

   assign debug_req_o    = 1'b0;
   assign unused_dbg_cfg = ^{8'(DebugHoldCycles), TypeDebug};
`endif

   logic unused_data;
   assign unused_data = ^{int_if.int_data_i[63:18], int_if.int_data_i[15:9], int_if.int_data_i[7:2]};

endmodule

// File: doc/l15_int_ctrl.md
L15_INT_CTRL -- requirements
Module: l15_int_ctrl

Interface
REQ-001 SHALL have parameter InitCycles, default 32768: cycles after reset before interrupt packets are accepted (SRAM init wait).
REQ-002 SHALL have parameter DebugHoldCycles, default 4, range 1..255: cycles debug_req_o stays high per debug packet.
REQ-003 SHALL have port clk_i, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port rst_ni, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port int_val_i, input, 1: L1.5 interrupt-return packet valid (pre-filtered returntype == interrupt).
REQ-006 SHALL have port int_ready_o, output, 1: packet accepted when int_val_i && int_ready_o.
REQ-007 SHALL have port int_data_i, input, 64: payload; [17:16] type (0 wake, 1 IPI, 2 ext IRQ, 3 debug), [8] set(1)/clear(0), [1:0] IRQ line mask.
REQ-008 SHALL have port core_rst_no, output, 1: core reset release, feeds the core wrapper reset_l.
REQ-009 SHALL have port irq_o, output, 2: level external interrupts (M, S).
REQ-010 SHALL have port ipi_o, output, 1: level inter-processor interrupt.
REQ-011 SHALL have port debug_req_o, output, 1: stretched debug request.
REQ-012 SHALL have port state_o, output, 2: FSM state (0 INIT, 1 WAIT_WAKE, 2 RUN).

Function
REQ-013 SHALL implement FSM INIT -> WAIT_WAKE -> RUN; no other transitions except reset to INIT.
REQ-014 INIT: counter runs 0..InitCycles-1, then WAIT_WAKE on the next edge; InitCycles=0 leaves INIT one cycle after reset release.
REQ-015 int_ready_o SHALL be 0 in INIT and 1 in WAIT_WAKE and RUN (combinational from state only, not from int_val_i).
REQ-016 Accepted wake packet in WAIT_WAKE SHALL move to RUN; core_rst_no goes 1 the cycle after acceptance and stays 1 until reset.
REQ-017 Wake packet in RUN SHALL be accepted and ignored.
REQ-018 IPI packet SHALL set (data[8]=1) or clear (data[8]=0) ipi_o, visible one cycle after acceptance, in WAIT_WAKE and RUN.
REQ-019 Ext IRQ packet SHALL set or clear (data[8]) each irq_o bit whose mask bit is 1, others held; mask 0 = no change; latency one cycle.
REQ-020 Debug packet SHALL load hold counter with DebugHoldCycles; debug_req_o = (counter != 0), high from the cycle after acceptance for exactly DebugHoldCycles cycles.
REQ-021 Debug packet while counter nonzero SHALL reload it (retrigger, no accumulation).
REQ-022 At most one packet per cycle; outputs not addressed by a packet SHALL hold.
REQ-023 int_data_i bits outside [17:16], [8], [1:0] SHALL be ignored.

Reset
REQ-024 rst_ni low at a clock edge SHALL force state INIT, counters 0, core_rst_no 0, irq_o 0, ipi_o 0, debug_req_o 0, regardless of operation in progress.
REQ-025 Reset mid-INIT, mid-debug-hold or in RUN SHALL restart the full InitCycles wait; no state survives.

Configuration
REQ-026 Macro L15_INT_CTRL_DEBUG_EN SHALL gate debug support.
REQ-027 Defined: REQ-020/021 apply.
REQ-028 Undefined: no hold counter, debug_req_o tied 0, type-3 packets accepted and discarded.

Verification
REQ-029 InitCycles=8, int_val_i high from reset release: int_ready_o 0 for 8 cycles, first acceptance in cycle 9, state_o 0 -> 1.
REQ-030 Wake packet (data=0x0) in WAIT_WAKE: state_o=2 and core_rst_no=1 next cycle; second wake packet: no change.
REQ-031 IPI set (0x1_0100) before wake: ipi_o=1 next cycle while core_rst_no=0; IPI clear (0x1_0000): ipi_o=0.
REQ-032 Ext IRQ 0x2_0103 -> irq_o=2'b11; 0x2_0002 -> irq_o=2'b01; 0x2_0100 -> irq_o=2'b01.
REQ-033 DebugHoldCycles=4, debug packet 0x3_0000, repeated 2 cycles later: debug_req_o high 6 consecutive cycles (macro on); stays 0 (macro off).
REQ-034 rst_ni low 1 cycle while in RUN with irq_o=3, ipi_o=1, debug hold active: all outputs 0, state_o=0, ready 0 for InitCycles.
